// File: rtl/dsc_pkg.sv
// Shared types and constants for the DSC stochastic number generators.
package dsc_pkg;

  // Default operand width; a frame is 2^width cycles long.
  localparam int SNG_WIDTH_DEFAULT = 6;
  localparam int SNG_FRAME_LEN     = 1 << SNG_WIDTH_DEFAULT;

  // Generator control state.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sng_state_e;

endpackage

// File: rtl/dsc_frame_ctr.sv
// Shared frame counter for counter-based SNGs: clear-on-accept, count enable,
// and a decode of the final count of the frame.
module dsc_frame_ctr #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] cnt,
  output logic             last
);

  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH-1:0] cnt_q;

  // Clear wins over enable so an accept on the last bit restarts at 0.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign last = (cnt_q == {WIDTH{1'b1}});

endmodule

// File: rtl/dsc_sng3.sv
// Three-lane counter-based stochastic number generator. One sorted triple per
// frame is expanded into thermometer-coded unary streams sharing one counter,
// so sorted inputs give nested lanes (a_bit >= b_bit >= c_bit) every cycle.
// Optional input-order checker: define DSC_SNG3_ORDER_CHECK_EN.
module dsc_sng3
  import dsc_pkg::*;
#(
  parameter int SNG_WIDTH = SNG_WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SNG_WIDTH-1:0] a_in,
  input  logic [SNG_WIDTH-1:0] b_in,
  input  logic [SNG_WIDTH-1:0] c_in,
  output logic                 bit_valid,
  output logic                 a_bit,
  output logic                 b_bit,
  output logic                 c_bit,
  output logic                 frame_last
`ifdef DSC_SNG3_ORDER_CHECK_EN
  ,
  output logic                 order_err
`endif
);

  sng_state_e           state_d, state_q;
  logic [SNG_WIDTH-1:0] a_d, a_q;
  logic [SNG_WIDTH-1:0] b_d, b_q;
  logic [SNG_WIDTH-1:0] c_d, c_q;
  logic [SNG_WIDTH-1:0] cnt;
  logic                 cnt_last;
  logic                 run;
  logic                 accept;

  assign run      = (state_q == RUN);
  assign in_ready = (state_q == IDLE) || (run && cnt_last);
  assign accept   = in_valid && in_ready;

  dsc_frame_ctr #(
    .WIDTH (SNG_WIDTH)
  ) u_frame_ctr (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .en   (run),
    .cnt  (cnt),
    .last (cnt_last)
  );

  // Next state and operand capture; the counter wraps to 0 on its own.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    if (accept) begin
      state_d = RUN;
      a_d     = a_in;
      b_d     = b_in;
      c_d     = c_in;
    end else if (run && cnt_last) begin
      state_d = IDLE;
    end
  end

  // Control state and operand registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
    end
  end

  assign bit_valid  = run;
  assign a_bit      = run && (cnt < a_q);
  assign b_bit      = run && (cnt < b_q);
  assign c_bit      = run && (cnt < c_q);
  assign frame_last = run && cnt_last;

`ifdef DSC_SNG3_ORDER_CHECK_EN
  logic order_err_d, order_err_q;

  // Sticky flag: any accepted triple that is not max/mid/min ordered.
  always_comb begin
    order_err_d = order_err_q;
    if (accept && !((a_in >= b_in) && (b_in >= c_in))) begin
      order_err_d = 1'b1;
    end
  end

  // Order error register, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      order_err_q <= 1'b0;
    end else begin
      order_err_q <= order_err_d;
    end
  end

  assign order_err = order_err_q;
`endif

endmodule

// File: tb/tb_dsc_sng3.sv
// Self-checking bench for dsc_sng3: table-driven frames, hand-written corner
// sequences and randomized triples against a "v ones then zeros" model.
module tb_dsc_sng3;

  localparam int W   = 6;
  localparam int LEN = 64;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_in, b_in, c_in;
  logic         bit_valid, a_bit, b_bit, c_bit, frame_last;
`ifdef DSC_SNG3_ORDER_CHECK_EN
  logic         order_err;
`endif

  int n_cmp = 0;
  int n_err = 0;
  bit err_model = 1'b0;

  dsc_sng3 #(.SNG_WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a_in       (a_in),
    .b_in       (b_in),
    .c_in       (c_in),
    .bit_valid  (bit_valid),
    .a_bit      (a_bit),
    .b_bit      (b_bit),
    .c_bit      (c_bit),
`ifdef DSC_SNG3_ORDER_CHECK_EN
    .order_err  (order_err),
`endif
    .frame_last (frame_last)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [W-1:0] a, b, c;
    int           ea, eb, ec;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " bit_valid"}, 32'(bit_valid), 0);
    chk({tag, " bits"}, {29'd0, a_bit, b_bit, c_bit}, 0);
    chk({tag, " frame_last"}, 32'(frame_last), 0);
    chk({tag, " in_ready"}, 32'(in_ready), 1);
`ifdef DSC_SNG3_ORDER_CHECK_EN
    chk({tag, " order_err"}, 32'(order_err), 32'(err_model));
`endif
  endtask

  // Present a triple, wait (bounded) for in_ready, and step past the accept.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
    int n;
    n        = 0;
    in_valid = 1'b1;
    a_in     = a;
    b_in     = b;
    c_in     = c;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: in_ready stayed %0d, expected 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    if (!((a >= b) && (b >= c))) err_model = 1'b1;
  endtask

  // One cycle of a frame, checked against the direct compare definition.
  task automatic check_cycle(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] c);
    chk($sformatf("cyc%0d bit_valid", i), 32'(bit_valid), 1);
    chk($sformatf("cyc%0d a_bit", i), 32'(a_bit), 32'(i < int'(a)));
    chk($sformatf("cyc%0d b_bit", i), 32'(b_bit), 32'(i < int'(b)));
    chk($sformatf("cyc%0d c_bit", i), 32'(c_bit), 32'(i < int'(c)));
    chk($sformatf("cyc%0d frame_last", i), 32'(frame_last), 32'(i == LEN - 1));
    chk($sformatf("cyc%0d in_ready", i), 32'(in_ready), 32'(i == LEN - 1));
  endtask

  // Full frame from bit 0; model emits the expected number of ones first,
  // then zeros. Ends on the last-bit cycle without stepping past it.
  task automatic check_frame(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                             input int ea, input int eb, input int ec);
    int ra, rb, rc, na, nb, nc;
    bit sorted;
    ra = ea; rb = eb; rc = ec;
    na = 0;  nb = 0;  nc = 0;
    sorted = (a >= b) && (b >= c);
    for (int i = 0; i < LEN; i++) begin
      chk($sformatf("f%0d bit_valid", i), 32'(bit_valid), 1);
      chk($sformatf("f%0d a_bit", i), 32'(a_bit), 32'(ra > 0));
      chk($sformatf("f%0d b_bit", i), 32'(b_bit), 32'(rb > 0));
      chk($sformatf("f%0d c_bit", i), 32'(c_bit), 32'(rc > 0));
      chk($sformatf("f%0d frame_last", i), 32'(frame_last), 32'(i == LEN - 1));
      chk($sformatf("f%0d in_ready", i), 32'(in_ready), 32'(i == LEN - 1));
`ifdef DSC_SNG3_ORDER_CHECK_EN
      chk($sformatf("f%0d order_err", i), 32'(order_err), 32'(err_model));
`endif
      if (sorted) begin
        chk($sformatf("f%0d nesting", i), 32'((a_bit >= b_bit) && (b_bit >= c_bit)), 1);
      end
      na += int'(a_bit);
      nb += int'(b_bit);
      nc += int'(c_bit);
      if (ra > 0) ra--;
      if (rb > 0) rb--;
      if (rc > 0) rc--;
      if (i < LEN - 1) tick();
    end
    chk("ones_a", na, ea);
    chk("ones_b", nb, eb);
    chk("ones_c", nc, ec);
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{a: 6'd40, b: 6'd20, c: 6'd5,  ea: 40, eb: 20, ec: 5};
    vecs[1] = '{a: 6'd63, b: 6'd0,  c: 6'd0,  ea: 63, eb: 0,  ec: 0};
    vecs[2] = '{a: 6'd0,  b: 6'd0,  c: 6'd0,  ea: 0,  eb: 0,  ec: 0};
    vecs[3] = '{a: 6'd63, b: 6'd63, c: 6'd63, ea: 63, eb: 63, ec: 63};
    vecs[4] = '{a: 6'd10, b: 6'd20, c: 6'd5,  ea: 10, eb: 20, ec: 5};

    rst      = 1'b1;
    in_valid = 1'b0;
    a_in     = '0;
    b_in     = '0;
    c_in     = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_idle("reset");
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk_idle("post_reset");

    // Table-driven frames, each followed by a return to IDLE.
    foreach (vecs[k]) begin
      send(vecs[k].a, vecs[k].b, vecs[k].c);
      check_frame(vecs[k].a, vecs[k].b, vecs[k].c, vecs[k].ea, vecs[k].eb, vecs[k].ec);
      tick();
      chk_idle($sformatf("vec%0d_end", k));
    end

    // Back-to-back: in_valid held; second triple taken on frame_last.
    send(6'd63, 6'd32, 6'd1);
    in_valid = 1'b1;
    a_in = 6'd10; b_in = 6'd10; c_in = 6'd10;
    check_frame(6'd63, 6'd32, 6'd1, 63, 32, 1);
    tick();
    in_valid = 1'b0;
    check_frame(6'd10, 6'd10, 6'd10, 10, 10, 10);
    tick();
    chk_idle("b2b_end");

    // Busy stall: new data offered at cnt=30 waits until the last bit.
    send(6'd40, 6'd20, 6'd5);
    for (int i = 0; i < LEN; i++) begin
      if (i == 30) begin
        in_valid = 1'b1;
        a_in = 6'd7; b_in = 6'd3; c_in = 6'd1;
      end
      check_cycle(i, 6'd40, 6'd20, 6'd5);
      if (i < LEN - 1) tick();
    end
    tick();
    in_valid = 1'b0;
    check_frame(6'd7, 6'd3, 6'd1, 7, 3, 1);
    tick();
    chk_idle("stall_end");

    // Reset mid-frame at cnt=30 aborts immediately.
    send(6'd40, 6'd20, 6'd5);
    for (int i = 0; i <= 30; i++) begin
      check_cycle(i, 6'd40, 6'd20, 6'd5);
      if (i < 30) tick();
    end
    rst = 1'b1;
    err_model = 1'b0;
    #1;
    chk_idle("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk_idle("mid_reset_rel");
    send(6'd12, 6'd8, 6'd3);
    check_frame(6'd12, 6'd8, 6'd3, 12, 8, 3);
    tick();
    chk_idle("after_reset_frame");

    // Randomized triples, mostly sorted, with random idle gaps or gapless.
    for (int r = 0; r < 20; r++) begin
      logic [W-1:0] ra, rb, rc, t;
      int gap;
      ra = W'($urandom_range(63, 0));
      rb = W'($urandom_range(63, 0));
      rc = W'($urandom_range(63, 0));
      if ($urandom_range(3, 0) != 0) begin
        if (ra < rb) begin t = ra; ra = rb; rb = t; end
        if (rb < rc) begin t = rb; rb = rc; rc = t; end
        if (ra < rb) begin t = ra; ra = rb; rb = t; end
      end
      gap = int'($urandom_range(3, 0));
      if (gap != 0) begin
        tick();
        chk_idle($sformatf("rnd%0d_idle", r));
        repeat (gap - 1) tick();
      end
      send(ra, rb, rc);
      check_frame(ra, rb, rc, int'(ra), int'(rb), int'(rc));
    end
    tick();
    chk_idle("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
